// File: rtl/fetch_issue_unit.sv
// PC and instruction-fetch stage: fetches from an async ROM, resolves
// branches locally and issues everything else to execute via valid/ready.
module fetch_issue_unit #(
  parameter int DATA_WIDTH = 38,
  parameter int ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  ex_valid,
  input  logic                  ex_ready,
  output logic [3:0]            opcode,
  output logic [1:0]            sel,
  output logic [15:0]           operand_a,
  output logic [15:0]           operand_b,
  output logic [ADDR_WIDTH-1:0] pc_out,
  input  logic                  flag_gt,
  input  logic                  flag_lt,
  input  logic                  flag_eq,
  input  logic                  flags_valid
);

  localparam logic [3:0] OP_CMP = 4'b0100;
  localparam logic [3:0] OP_B   = 4'b0101;
  localparam logic [3:0] OP_BGT = 4'b0110;
  localparam logic [3:0] OP_BLT = 4'b0111;
  localparam logic [3:0] OP_BEQ = 4'b1000;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    ISSUE  = 2'd1,
    BRANCH = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]   ir_pc_q, ir_pc_d;
  logic [DATA_WIDTH-1:0]   ir_q, ir_d;
  logic                    cmp_q, cmp_d;

  logic [3:0]              ir_op;
  logic [3:0]              rom_op;
  logic [ADDR_WIDTH-1:0]   pc_inc;
  logic [ADDR_WIDTH-1:0]   target;
  logic                    rom_is_br;
  logic                    take;

  assign ir_op  = ir_q[DATA_WIDTH-1 -: 4];
  assign rom_op = rom_data[DATA_WIDTH-1 -: 4];
  assign pc_inc = pc_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  assign target = ir_q[ADDR_WIDTH-1:0];

  assign rom_is_br = (rom_op == OP_B) || (rom_op == OP_BGT) ||
                     (rom_op == OP_BLT) || (rom_op == OP_BEQ);

  assign rom_addr  = pc_q;
  assign ex_valid  = (state_q == ISSUE);
  assign opcode    = ir_op;
  assign sel       = ir_q[DATA_WIDTH-5 -: 2];
  assign operand_a = ir_q[31:16];
  assign operand_b = ir_q[15:0];
  assign pc_out    = ir_pc_q;

  always_comb begin
    take = 1'b0;
    unique case (1'b1)
      (ir_op == OP_B):   take = 1'b1;
      (ir_op == OP_BGT): take = flag_gt;
      (ir_op == OP_BLT): take = flag_lt;
      (ir_op == OP_BEQ): take = flag_eq;
      default:           take = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ir_pc_d = ir_pc_q;
    cmp_d   = flags_valid ? 1'b0 : cmp_q;
    unique case (state_q)
      FETCH: begin
        ir_d    = rom_data;
        ir_pc_d = pc_q;
        state_d = rom_is_br ? BRANCH : ISSUE;
      end
      ISSUE: begin
        if (ex_ready) begin
          pc_d    = pc_inc;
          state_d = FETCH;
          // a cmp accepted this cycle beats a same-cycle flags_valid
          if (ir_op == OP_CMP) cmp_d = 1'b1;
        end
      end
      BRANCH: begin
        if (ir_op == OP_B || !cmp_q) begin
          pc_d    = take ? target : pc_inc;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_VECTOR;
      ir_q    <= '0;
      ir_pc_q <= '0;
      cmp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ir_pc_q <= ir_pc_d;
      cmp_q   <= cmp_d;
    end
  end

endmodule

// File: tb/tb_fetch_issue_unit.sv
// Directed bench for fetch_issue_unit with an async ROM model.
// Each task builds a tiny program, runs it and checks cycle by cycle.
module tb_fetch_issue_unit;

  logic        clk;
  logic        rst;
  logic [11:0] rom_addr;
  logic [37:0] rom_data;
  logic        ex_valid;
  logic        ex_ready;
  logic [3:0]  opcode;
  logic [1:0]  sel;
  logic [15:0] operand_a;
  logic [15:0] operand_b;
  logic [11:0] pc_out;
  logic        flag_gt;
  logic        flag_lt;
  logic        flag_eq;
  logic        flags_valid;

  logic [37:0] rom [0:4095];
  int          vectors;
  int          miscompares;

  assign rom_data = rom[rom_addr];

  fetch_issue_unit #(
    .DATA_WIDTH(38),
    .ADDR_WIDTH(12),
    .RESET_VECTOR(12'h000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .ex_valid(ex_valid),
    .ex_ready(ex_ready),
    .opcode(opcode),
    .sel(sel),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .pc_out(pc_out),
    .flag_gt(flag_gt),
    .flag_lt(flag_lt),
    .flag_eq(flag_eq),
    .flags_valid(flags_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [37:0] ins(
    input logic [3:0] op, input logic [1:0] s,
    input logic [15:0] a, input logic [15:0] b);
    return {op, s, a, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_addr(input string nm, input logic [11:0] exp);
    vectors++;
    if (rom_addr !== exp) begin
      miscompares++;
      $display("FAIL %s: rom_addr=%h expected %h", nm, rom_addr, exp);
    end
  endtask

  task automatic chk_valid(input string nm, input logic exp);
    vectors++;
    if (ex_valid !== exp) begin
      miscompares++;
      $display("FAIL %s: ex_valid=%b expected %b", nm, ex_valid, exp);
    end
  endtask

  task automatic test_reset();
    rom[0] = ins(4'b0001, 2'b00, 16'h0000, 16'h0001);
    ex_ready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    vectors++;
    if ({ex_valid, opcode, sel, operand_a, operand_b, pc_out, rom_addr}
        !== 51'd0) begin
      miscompares++;
      $display("FAIL reset_outs: v=%b op=%h s=%h a=%h b=%h pc=%h ra=%h expected all 0",
               ex_valid, opcode, sel, operand_a, operand_b, pc_out, rom_addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_first_issue();
    rom[0] = ins(4'b0001, 2'b00, 16'h0000, 16'h0001);
    ex_ready = 1'b1;
    do_reset();
    chk_valid("first_fetch_valid", 1'b0);
    tick();
    chk_valid("first_issue_valid", 1'b1);
    vectors++;
    if ({opcode, sel, operand_a, operand_b, pc_out} !==
        {4'b0001, 2'b00, 16'h0000, 16'h0001, 12'h000}) begin
      miscompares++;
      $display("FAIL first_issue_fields: op=%h s=%h a=%h b=%h pc=%h expected 1 0 0000 0001 000",
               opcode, sel, operand_a, operand_b, pc_out);
    end
    tick();
    chk_valid("first_after_valid", 1'b0);
    chk_addr("first_next_addr", 12'h001);
  endtask

  task automatic test_stall();
    rom[0]  = ins(4'b0101, 2'b00, 16'h0000, 16'h000F);
    rom[15] = ins(4'b0001, 2'b01, 16'h0001, 16'h0002);
    ex_ready = 1'b0;
    do_reset();
    tick();
    tick();
    chk_addr("stall_jump15", 12'h00F);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk_valid("stall_hold_valid", 1'b1);
      chk_addr("stall_hold_addr", 12'h00F);
      vectors++;
      if ({opcode, sel, operand_a, operand_b, pc_out} !==
          {4'b0001, 2'b01, 16'h0001, 16'h0002, 12'h00F}) begin
        miscompares++;
        $display("FAIL stall_hold_fields: op=%h s=%h a=%h b=%h pc=%h expected 1 1 0001 0002 00f",
                 opcode, sel, operand_a, operand_b, pc_out);
      end
      tick();
    end
    ex_ready = 1'b1;
    chk_valid("stall_cycle4_valid", 1'b1);
    tick();
    chk_valid("stall_accepted_valid", 1'b0);
    chk_addr("stall_next_addr", 12'h010);
  endtask

  task automatic test_cmp_branch();
    rom[0]  = ins(4'b0101, 2'b00, 16'h0000, 16'h005F);
    rom[95] = ins(4'b0100, 2'b00, 16'h0001, 16'h0000);
    rom[96] = ins(4'b0110, 2'b00, 16'h0000, 16'h0062);
    rom[98] = ins(4'b0000, 2'b00, 16'h0000, 16'h0000);
    ex_ready = 1'b1;
    flag_gt = 1'b1;
    flag_lt = 1'b0;
    flag_eq = 1'b0;
    do_reset();
    tick();
    tick();
    tick();
    chk_valid("cmp_issue_valid", 1'b1);
    vectors++;
    if (opcode !== 4'b0100 || pc_out !== 12'h05F) begin
      miscompares++;
      $display("FAIL cmp_issue: op=%h pc=%h expected 4 05f", opcode, pc_out);
    end
    tick();
    chk_addr("cmp_fetch96", 12'h060);
    tick();
    chk_addr("bgt_stall1", 12'h060);
    chk_valid("bgt_stall1_valid", 1'b0);
    tick();
    chk_addr("bgt_stall2", 12'h060);
    chk_valid("bgt_stall2_valid", 1'b0);
    flags_valid = 1'b1;
    tick();
    flags_valid = 1'b0;
    chk_addr("bgt_flag_cycle", 12'h060);
    chk_valid("bgt_flag_valid", 1'b0);
    tick();
    chk_addr("bgt_taken", 12'h062);
    tick();
    chk_valid("nop98_valid", 1'b1);
    vectors++;
    if (pc_out !== 12'h062) begin
      miscompares++;
      $display("FAIL nop98_pc: pc_out=%h expected 062", pc_out);
    end
  endtask

  task automatic test_uncond_pending();
    rom[0]   = ins(4'b0101, 2'b00, 16'h0000, 16'h0066);
    rom[102] = ins(4'b0100, 2'b00, 16'h0001, 16'h0000);
    rom[103] = ins(4'b0101, 2'b00, 16'h0000, 16'h0069);
    ex_ready = 1'b1;
    do_reset();
    tick();
    tick();
    tick();
    tick();
    chk_addr("b_pending_at103", 12'h067);
    tick();
    chk_valid("b_pending_valid", 1'b0);
    tick();
    chk_addr("b_pending_target", 12'h069);
  endtask

  task automatic test_blt_not_taken();
    rom[0]   = ins(4'b0101, 2'b00, 16'h0000, 16'h006D);
    rom[109] = ins(4'b0111, 2'b00, 16'h0000, 16'h0062);
    flag_lt = 1'b0;
    do_reset();
    tick();
    tick();
    chk_addr("blt_at109", 12'h06D);
    tick();
    chk_valid("blt_no_issue", 1'b0);
    tick();
    chk_addr("blt_fallthru", 12'h06E);
    chk_valid("blt_fallthru_valid", 1'b0);
  endtask

  task automatic test_wrap_and_mask();
    rom[0]    = ins(4'b0101, 2'b00, 16'h0000, 16'h0FFF);
    rom[4095] = ins(4'b0011, 2'b10, 16'h1234, 16'h5678);
    ex_ready = 1'b1;
    do_reset();
    tick();
    tick();
    tick();
    vectors++;
    if (pc_out !== 12'hFFF || operand_a !== 16'h1234) begin
      miscompares++;
      $display("FAIL wrap_issue: pc_out=%h a=%h expected fff 1234", pc_out, operand_a);
    end
    tick();
    chk_addr("wrap_to_zero", 12'h000);
    rom[0] = ins(4'b1000, 2'b00, 16'h0000, 16'h1062);
    flag_eq = 1'b1;
    do_reset();
    tick();
    tick();
    chk_addr("beq_target_mask", 12'h062);
    flag_eq = 1'b0;
  endtask

  task automatic test_set_wins();
    rom[0] = ins(4'b0100, 2'b00, 16'h0002, 16'h0003);
    rom[1] = ins(4'b0110, 2'b00, 16'h0000, 16'h0062);
    flag_gt = 1'b1;
    ex_ready = 1'b1;
    do_reset();
    tick();
    flags_valid = 1'b1;
    tick();
    flags_valid = 1'b0;
    tick();
    tick();
    chk_addr("setwins_stall", 12'h001);
    flags_valid = 1'b1;
    tick();
    flags_valid = 1'b0;
    tick();
    chk_addr("setwins_taken", 12'h062);
  endtask

  task automatic test_reset_in_stall();
    rom[0] = ins(4'b0100, 2'b00, 16'h0002, 16'h0003);
    rom[1] = ins(4'b1000, 2'b00, 16'h0000, 16'h0062);
    flag_eq = 1'b1;
    ex_ready = 1'b1;
    do_reset();
    tick();
    tick();
    tick();
    tick();
    chk_addr("rst_br_stalled", 12'h001);
    rst = 1'b1;
    tick();
    chk_addr("rst_br_addr", 12'h000);
    chk_valid("rst_br_valid", 1'b0);
    rst = 1'b0;
    rom[0] = ins(4'b1000, 2'b00, 16'h0000, 16'h0062);
    tick();
    tick();
    chk_addr("rst_br_pending_clr", 12'h062);
    rom[0] = ins(4'b0001, 2'b11, 16'h00AA, 16'h00BB);
    ex_ready = 1'b0;
    do_reset();
    tick();
    tick();
    chk_valid("rst_iss_stalled", 1'b1);
    rst = 1'b1;
    ex_ready = 1'b1;
    tick();
    chk_valid("rst_iss_valid", 1'b0);
    chk_addr("rst_iss_addr", 12'h000);
    vectors++;
    if (opcode !== 4'b0000 || operand_a !== 16'h0000) begin
      miscompares++;
      $display("FAIL rst_iss_fields: op=%h a=%h expected 0 0000", opcode, operand_a);
    end
    rst = 1'b0;
    flag_eq = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < 4096; i++) rom[i] = '0;
    rst = 1'b1;
    ex_ready = 1'b0;
    flag_gt = 1'b0;
    flag_lt = 1'b0;
    flag_eq = 1'b0;
    flags_valid = 1'b0;
    test_reset();
    test_first_issue();
    test_stall();
    test_cmp_branch();
    test_uncond_pending();
    test_blt_not_taken();
    test_wrap_and_mask();
    test_set_wins();
    test_reset_in_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_issue_unit.md
Name: fetch_issue_unit

Overview:
- Program-counter and instruction-fetch stage sitting directly downstream of the asynchronous instruction ROM.
- Drives the ROM address, latches the 38-bit word into an instruction register and splits it into opcode/s/a/b fields.
- Resolves branches locally (b, bgt, blt, beq) using flags from the execute stage.
- Issues every non-branch instruction to execute through a valid/ready handshake.

Parameters:
- DATA_WIDTH, 38, instruction word width; layout {opcode[37:34], s[33:32], a[31:16], b[15:0]}.
- ADDR_WIDTH, 12, ROM address width and PC width.
- RESET_VECTOR, 0, PC value after reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- rom_addr  output  ADDR_WIDTH  address to ROM; equals PC combinationally.
- rom_data  input  DATA_WIDTH  ROM word; valid in the same cycle as rom_addr (asynchronous ROM).
- ex_valid  output  1  issued instruction fields are valid.
- ex_ready  input  1  execute stage accepts the instruction this cycle.
- opcode  output  4  issued opcode.
- sel  output  2  issued s field (addressing-mode select).
- operand_a  output  16  issued a field.
- operand_b  output  16  issued b field.
- pc_out  output  ADDR_WIDTH  ROM address of the issued instruction.
- flag_gt, flag_lt, flag_eq  input  1 each  compare flags from execute; held stable between compares.
- flags_valid  input  1  one-cycle pulse when execute has finished a cmp and the flags are updated.

Behaviour:
- Reset:
  - PC=RESET_VECTOR; state=FETCH; ex_valid=0.
  - opcode, sel, operand_a, operand_b and pc_out all 0.
  - cmp_pending=0.
  - Reset wins over every other event in the same cycle.
- Branch opcodes: 0101 b (unconditional); 0110 bgt; 0111 blt; 1000 beq.
- Issued opcodes: all other opcodes (0000–0100, 1001–1111) are issued unchanged. Unknown opcodes are not trapped.
- FETCH:
  - IR<=rom_data; ir_pc<=PC.
  - Next state is BRANCH if IR opcode is a branch, else ISSUE.
  - Costs 1 cycle.
- ISSUE:
  - ex_valid=1; fields and pc_out driven from IR/ir_pc.
  - While ex_ready=0: stay in ISSUE; all outputs and PC held.
  - On ex_valid&ex_ready: PC<=PC+1, go to FETCH; ex_valid deasserts the following cycle.
  - If the accepted opcode is 0100 (cmp), set cmp_pending.
  - Throughput: 2 cycles per instruction at best.
- cmp_pending:
  - Cleared on flags_valid.
  - If set (cmp accepted) and cleared (flags_valid) in the same cycle, set wins.
- BRANCH:
  - Never raises ex_valid.
  - Opcode 0101: PC<=b[ADDR_WIDTH-1:0] immediately, go to FETCH; ignores cmp_pending.
  - Conditional opcodes: stall in BRANCH while cmp_pending=1.
    - flags_valid in a stall cycle clears cmp_pending; flags are evaluated the next cycle.
  - When cmp_pending=0: evaluate the flag (gt/lt/eq respectively).
    - Taken: PC<=b[ADDR_WIDTH-1:0].
    - Not taken: PC<=PC+1.
    - Then go to FETCH.
- Arithmetic:
  - PC increments modulo 2^ADDR_WIDTH, so 0xFFF+1=0x000.
  - Branch target takes the low ADDR_WIDTH bits of b; upper bits are ignored.
- Outputs are registered from IR. They may hold stale values while ex_valid=0; the execute stage must ignore them.
- Reset asserted during an ISSUE stall or a BRANCH stall:
  - Next cycle ex_valid=0, PC=RESET_VECTOR, cmp_pending=0.
  - No pending acceptance survives.

Test Plan:
1. Reset, ROM[0]=mov r0,#1 ({0001,00,0000,0001}), ex_ready=1 -> cycle 1 after reset: ex_valid=1, opcode=0001, sel=00, a=0x0000, b=0x0001, pc_out=0; then rom_addr=1.
2. Issue mov r1,r2 at addr 15 with ex_ready=0 for 3 cycles -> ex_valid, fields and rom_addr=15 held for 3 cycles; accepted on cycle 4; rom_addr=16 next.
3. cmp r1,r0 at 95, bgt 0x062 at 96, flags_valid pulsed 3 cycles after cmp accept with flag_gt=1 -> unit stalls in BRANCH at rom_addr 96 until flags consumed; next fetch at 98 (0x062); 96 never issued.
4. blt 0x062 at 109 with cmp_pending=0, flag_lt=0 -> rom_addr=110 next; no ex_valid for 109.
5. b 0x069 at 103 with cmp_pending=1 -> no stall; next rom_addr=105.
6. Non-branch at 0xFFF -> next rom_addr=0x000. Branch with b=0x1062 and condition true -> rom_addr=0x062. Assert rst during a BRANCH stall -> rom_addr=0, ex_valid=0 on the following cycle.
